// File: rtl/costas_loop_filter_ma_pi.sv
// Costas loop filter: run-time selectable moving average over 2^L phase
// detector samples, optionally followed by a shift-gain PI stage with
// saturating arithmetic and a sticky saturation flag. Fixed 2-cycle latency.
module costas_loop_filter_ma_pi #(
  parameter int IN_W     = 34,
  parameter int MAX_LOG2 = 6,
  parameter int OUT_W    = 35
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic [$clog2(MAX_LOG2+1)-1:0]     cfg_log2_len,
  input  logic                              cfg_mode,
  input  logic [4:0]                        cfg_kp_shift,
  input  logic [4:0]                        cfg_ki_shift,
  input  logic signed [IN_W-1:0]            pd,
  input  logic                              pd_valid,
  output logic signed [OUT_W-1:0]           dout,
  output logic                              dout_valid,
  output logic                              warm,
  output logic                              sat_flag
);

  localparam int LW    = $clog2(MAX_LOG2 + 1);
  localparam int DEPTH = 1 << MAX_LOG2;
  localparam int SUM_W = IN_W + MAX_LOG2;

  // Floor average: arithmetic shift of the window sum, which always fits IN_W.
  function automatic logic signed [IN_W-1:0] floor_avg(input logic signed [SUM_W-1:0] s,
                                                       input logic [LW-1:0] l);
    return IN_W'(s >>> l);
  endfunction

  // True when a one-bit-wide result no longer fits OUT_W.
  function automatic logic ovf(input logic signed [OUT_W:0] v);
    return v[OUT_W] != v[OUT_W-1];
  endfunction

  // Clamp a one-bit-wide result to the OUT_W signed range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [OUT_W:0] v);
    logic signed [OUT_W-1:0] max_v;
    logic signed [OUT_W-1:0] min_v;
    max_v = {1'b0, {(OUT_W-1){1'b1}}};
    min_v = {1'b1, {(OUT_W-1){1'b0}}};
    if (ovf(v)) return v[OUT_W] ? min_v : max_v;
    return v[OUT_W-1:0];
  endfunction

  // Sample history; never zeroed, stale slots are masked by the fill count.
  logic signed [IN_W-1:0]  mem [DEPTH];

  logic [MAX_LOG2-1:0]     wp_p1;
  logic [LW-1:0]           len_p1;
  logic [MAX_LOG2:0]       fill_p1;
  logic signed [SUM_W-1:0] sum_p1;
  logic                    warm_p1;
  logic                    vld_p1;

  logic [LW-1:0]           len_cfg;
  logic                    len_chg;
  logic [MAX_LOG2:0]       win_cur;
  logic [MAX_LOG2-1:0]     rd_ptr;
  logic signed [SUM_W-1:0] pd_x;
  logic signed [SUM_W-1:0] old_x;
  logic signed [SUM_W-1:0] sum_nxt;

  logic signed [IN_W-1:0]  avg_p1;
  logic signed [OUT_W:0]   avg_x;
  logic signed [OUT_W:0]   integ_sum;
  logic signed [OUT_W:0]   pi_sum;
  logic signed [OUT_W-1:0] integ_new;
  logic signed [OUT_W-1:0] pi_out;
  logic                    pi_ovf;
  logic signed [OUT_W-1:0] integ_p2;

  // Clamp the requested length, spot a change, and form the next window sum.
  always_comb begin
    len_cfg = (cfg_log2_len > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : cfg_log2_len;
    len_chg = (len_cfg != len_p1);
    win_cur = (MAX_LOG2+1)'(1) << len_p1;
    // Slot leaving the window; with the full depth this is the slot about to be overwritten.
    rd_ptr  = wp_p1 - win_cur[MAX_LOG2-1:0];
    pd_x    = SUM_W'(pd);
    old_x   = warm_p1 ? SUM_W'(mem[rd_ptr]) : {SUM_W{1'b0}};
    sum_nxt = sum_p1 + pd_x - old_x;
  end

  // Write accepted samples into the history; a cleared cycle discards its sample.
  always_ff @(posedge clk) begin
    if (rst_n && pd_valid && !clear) mem[wp_p1] <= pd;
  end

  // ---- stage 0 -> stage 1: window sum, fill count, warm, length tracking ----
  // Accumulate the running sum; a length change restarts the window, keeping wp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1  <= '0;
      fill_p1 <= '0;
      warm_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      wp_p1   <= '0;
      len_p1  <= '0;
    end else begin
      len_p1 <= len_cfg;
      if (clear) begin
        sum_p1  <= '0;
        fill_p1 <= '0;
        warm_p1 <= 1'b0;
        vld_p1  <= 1'b0;
      end else begin
        vld_p1 <= pd_valid;
        if (pd_valid) wp_p1 <= wp_p1 + 1'b1;
        if (len_chg) begin
          // The coincident sample, if any, opens the new window.
          sum_p1  <= pd_valid ? pd_x : {SUM_W{1'b0}};
          fill_p1 <= (MAX_LOG2+1)'(pd_valid);
          warm_p1 <= pd_valid && (len_cfg == '0);
        end else if (pd_valid) begin
          sum_p1 <= sum_nxt;
          if (!warm_p1) fill_p1 <= fill_p1 + 1'b1;
          warm_p1 <= warm_p1 || ((fill_p1 + 1'b1) == win_cur);
        end
      end
    end
  end

  assign warm = warm_p1;

  // Average and PI arithmetic, each sum carried one bit wide before clamping.
  always_comb begin
    avg_p1    = floor_avg(sum_p1, len_p1);
    avg_x     = (OUT_W+1)'(avg_p1);
    integ_sum = (OUT_W+1)'(integ_p2) + (avg_x >>> cfg_ki_shift);
    integ_new = sat_out(integ_sum);
    pi_sum    = (avg_x >>> cfg_kp_shift) + (OUT_W+1)'(integ_new);
    pi_out    = sat_out(pi_sum);
    pi_ovf    = ovf(integ_sum) | ovf(pi_sum);
  end

  // ---- stage 1 -> stage 2: registered output, integrator, sticky flag ----
  // Register the filter output; dout holds between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      integ_p2   <= '0;
      sat_flag   <= 1'b0;
    end else if (clear) begin
      dout_valid <= 1'b0;
      integ_p2   <= '0;
      sat_flag   <= 1'b0;
    end else begin
      dout_valid <= vld_p1;
      if (vld_p1) begin
        if (cfg_mode) begin
          dout     <= pi_out;
          integ_p2 <= integ_new;
          if (pi_ovf) sat_flag <= 1'b1;
        end else begin
          dout <= OUT_W'(avg_p1);
        end
      end
      // A window restart also restarts the integrator.
      if (len_chg) integ_p2 <= '0;
    end
  end

endmodule

// File: tb/tb_costas_loop_filter_ma_pi.sv
// Testbench for costas_loop_filter_ma_pi: directed cases plus randomized
// traffic compared against a window-list reference model.
module tb_costas_loop_filter_ma_pi;

  localparam int IN_W     = 34;
  localparam int MAX_LOG2 = 6;
  localparam int OUT_W    = 35;
  localparam int LW       = $clog2(MAX_LOG2 + 1);
  localparam longint OMAX = (64'sd1 <<< (OUT_W-1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OUT_W-1));

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    clear;
  logic [LW-1:0]           cfg_log2_len;
  logic                    cfg_mode;
  logic [4:0]              cfg_kp_shift;
  logic [4:0]              cfg_ki_shift;
  logic signed [IN_W-1:0]  pd;
  logic                    pd_valid;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic                    warm;
  logic                    sat_flag;

  always #5 clk = ~clk;

  costas_loop_filter_ma_pi #(.IN_W(IN_W), .MAX_LOG2(MAX_LOG2), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .cfg_log2_len (cfg_log2_len),
    .cfg_mode     (cfg_mode),
    .cfg_kp_shift (cfg_kp_shift),
    .cfg_ki_shift (cfg_ki_shift),
    .pd           (pd),
    .pd_valid     (pd_valid),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .warm         (warm),
    .sat_flag     (sat_flag)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  longint hist[$];
  int     m_len;
  bit     m_s1v;
  longint m_s1_avg;
  longint m_integ;
  bit     m_sat;
  longint m_dout;
  bit     m_dv;
  bit     m_warm;
  longint got_q[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint clampo(input longint v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_len = 0; m_s1v = 0; m_s1_avg = 0; m_integ = 0;
    m_sat = 0; m_dout = 0; m_dv = 0; m_warm = 0;
  endtask

  // One clock edge of the filter described as a list of window samples.
  task automatic model_edge(input bit v, input longint p, input bit clr);
    int     lc;
    bit     chg;
    longint t;
    longint s;
    int     n;
    lc  = (int'(cfg_log2_len) > MAX_LOG2) ? MAX_LOG2 : int'(cfg_log2_len);
    chg = (lc != m_len);
    // output side uses the average formed on the previous edge
    if (clr) begin
      m_dv = 0; m_integ = 0; m_sat = 0;
    end else begin
      m_dv = m_s1v;
      if (m_s1v) begin
        if (cfg_mode) begin
          t = m_integ + (m_s1_avg >>> cfg_ki_shift);
          if (clampo(t) != t) m_sat = 1;
          m_integ = clampo(t);
          t = (m_s1_avg >>> cfg_kp_shift) + m_integ;
          if (clampo(t) != t) m_sat = 1;
          m_dout = clampo(t);
        end else begin
          m_dout = m_s1_avg;
        end
      end
      if (chg) m_integ = 0;
    end
    // window side
    if (clr) begin
      hist.delete();
      m_s1v = 0;
    end else begin
      if (chg) hist.delete();
      if (v) begin
        hist.push_back(p);
        if (hist.size() > (1 << MAX_LOG2)) void'(hist.pop_front());
      end
      m_s1v = v;
    end
    m_len = lc;
    n = (hist.size() < (1 << m_len)) ? hist.size() : (1 << m_len);
    s = 0;
    for (int i = hist.size() - n; i < hist.size(); i++) s += hist[i];
    m_s1_avg = s >>> m_len;
    m_warm   = (hist.size() >= (1 << m_len));
  endtask

  task automatic step(input bit v, input longint p, input bit clr);
    pd_valid = v;
    pd       = IN_W'(p);
    clear    = clr;
    @(posedge clk);
    model_edge(v, p, clr);
    #1;
    chk("dout_valid", longint'(dout_valid), longint'(m_dv));
    chk("dout", longint'(dout), m_dout);
    chk("warm", longint'(warm), longint'(m_warm));
    chk("sat_flag", longint'(sat_flag), longint'(m_sat));
    if (dout_valid) got_q.push_back(longint'(dout));
    pd_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dout", longint'(dout), 0);
    chk("rst_dout_valid", longint'(dout_valid), 0);
    chk("rst_warm", longint'(warm), 0);
    chk("rst_sat_flag", longint'(sat_flag), 0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_list(input string tag, input longint exp[$]);
    chk({tag, "_count"}, longint'(got_q.size()), longint'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk(tag, got_q[i], exp[i]);
    got_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint big;
    longint p;
    rst_n        = 1'b0;
    clear        = 1'b0;
    pd_valid     = 1'b0;
    pd           = '0;
    cfg_log2_len = LW'(2);
    cfg_mode     = 1'b0;
    cfg_kp_shift = '0;
    cfg_ki_shift = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", longint'(dout), 0);
    chk("rst_dout_valid", longint'(dout_valid), 0);
    chk("rst_warm", longint'(warm), 0);
    chk("rst_sat_flag", longint'(sat_flag), 0);
    rst_n = 1'b1;

    // Mode 0, L=2, six samples of +4
    step(0, 0, 0);
    got_q.delete();
    for (int i = 0; i < 6; i++) begin
      step(1, 4, 0);
      if (i == 2) chk("l2_warm_low", longint'(warm), 0);
      if (i == 3) chk("l2_warm_high", longint'(warm), 1);
    end
    step(0, 0, 0); step(0, 0, 0);
    chk_list("l2_avg", '{1, 2, 3, 4, 4, 4});

    // Mode 0, L=0 passes samples through
    cfg_log2_len = LW'(0);
    step(0, 0, 0);
    step(1, -7, 0);
    chk("l0_warm", longint'(warm), 1);
    step(1, 5, 0);
    step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    chk_list("l0_pass", '{-7, 5, 0});

    // Mode 0, L=1 floors toward minus infinity
    cfg_log2_len = LW'(1);
    step(0, 0, 0);
    step(1, -1, 0);
    step(1, -2, 0);
    step(0, 0, 0); step(0, 0, 0);
    chk_list("l1_floor", '{-1, -2});

    // Mode 1, L=0, unit gains, then saturation
    cfg_mode     = 1'b1;
    cfg_log2_len = LW'(0);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    big = (64'sd1 <<< 33) - 1;
    for (int i = 0; i < 3; i++) step(1, big, 0);
    step(0, 0, 0); step(0, 0, 0);
    chk_list("pi_sat", '{2, 3, 4, OMAX, OMAX, OMAX});
    chk("pi_sat_flag_set", longint'(sat_flag), 1);
    step(0, 0, 0);
    chk("pi_sat_flag_sticky", longint'(sat_flag), 1);
    step(0, 0, 1);
    chk("pi_sat_flag_cleared", longint'(sat_flag), 0);
    cfg_mode = 1'b0;

    // Length change coinciding with a sample
    cfg_log2_len = LW'(3);
    step(0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 8, 0);
    chk("lc_warm_l3", longint'(warm), 1);
    step(0, 0, 0); step(0, 0, 0);
    got_q.delete();
    cfg_log2_len = LW'(1);
    step(1, 8, 0);
    chk("lc_warm_drop", longint'(warm), 0);
    step(1, 8, 0);
    chk("lc_warm_back", longint'(warm), 1);
    step(0, 0, 0); step(0, 0, 0);
    chk_list("lc_avg", '{4, 8});

    // clear with a sample in flight and a coincident sample
    step(0, 0, 0);
    got_q.delete();
    step(1, 10, 0);
    step(1, 20, 1);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("clr_no_valid", longint'(got_q.size()), 0);
    step(1, 6, 0);
    step(0, 0, 0); step(0, 0, 0);
    chk_list("clr_after", '{3});

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) cfg_log2_len = LW'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) cfg_mode = ~cfg_mode;
      if ($urandom_range(0, 29) == 0) begin
        cfg_kp_shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
        cfg_ki_shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 1) == 0) begin
        p = longint'($urandom_range(0, 200)) - 100;
      end else begin
        p = longint'({$urandom(), $urandom()});
        p = (p <<< (64 - IN_W)) >>> (64 - IN_W);
      end
      if (i == 1500) do_reset();
      step(($urandom_range(0, 3) != 0), p, ($urandom_range(0, 99) == 0));
    end
    step(0, 0, 0); step(0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
